voxel_bram_initiator: RTL and testbench

Initiator-side controller for the LiDAR voxel-count BRAM port: it owns the `read_en`/`write_en`/`addr`/`data_in` inputs of the BRAM responder and consumes its registered `data_out`. It turns voxel-hit updates into read-modify-write accumulations, serves single-word readout requests, and clears the whole array by a write sweep, so the array itself needs no reset loop. It sits between the voxelizer front end and the BRAM.

---
 rtl/voxel_bram_pkg.sv | 19 +
 rtl/voxel_sat_adder.sv | 25 ++
 rtl/voxel_bram_initiator.sv | 123 ++++++++++++
 tb/tb_voxel_bram_initiator.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voxel_bram_pkg.sv
// Shared definitions for the voxel-count BRAM port: default widths, depth and initiator FSM states.
package voxel_bram_pkg;

    localparam int unsigned VOX_ADDR_W = 15;
    localparam int unsigned VOX_DATA_W = 32;
    localparam int unsigned VOX_INC_W  = 16;
    localparam int unsigned VOX_DEPTH  = 1 << VOX_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RMW_RD,
        RMW_WAIT,
        RMW_WR,
        RD_ISSUE,
        RD_WAIT
    } vox_state_e;

endpackage

// File: rtl/voxel_sat_adder.sv
// Voxel counter accumulate: zero-extended increment added to the stored count.
// Saturates at all-ones when VOXEL_BRAM_SAT_EN is defined, otherwise wraps; ovf flags the carry out.
module voxel_sat_adder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned INC_W  = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [INC_W-1:0]  b,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    logic [DATA_W:0] full;

    always_comb begin
        full = (DATA_W+1)'(a) + (DATA_W+1)'(b);
        ovf  = full[DATA_W];
`ifdef VOXEL_BRAM_SAT_EN
        sum  = ovf ? {DATA_W{1'b1}} : full[DATA_W-1:0];
`else
        sum  = full[DATA_W-1:0];
`endif
    end

endmodule

// File: rtl/voxel_bram_initiator.sv
// Initiator for the voxel-count BRAM: read-modify-write updates, single-word readout, clear sweep.
// Optional saturation of accumulations and the sticky sat_seen flag: define VOXEL_BRAM_SAT_EN.
module voxel_bram_initiator
    import voxel_bram_pkg::*;
#(
    parameter int unsigned ADDR_W = VOX_ADDR_W,
    parameter int unsigned DATA_W = VOX_DATA_W,
    parameter int unsigned INC_W  = VOX_INC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_start,
    output logic              busy,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [INC_W-1:0]  upd_inc,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_rsp_valid,
    output logic [DATA_W-1:0] rd_rsp_data,
    output logic              sat_seen,
    output logic              bram_read_en,
    output logic              bram_write_en,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

`ifdef VOXEL_BRAM_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    vox_state_e        state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [INC_W-1:0]  inc_q;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_c;
    logic              ovf_c;
    logic              sat_q;
    logic              rd_hs;
    logic              upd_hs;

    voxel_sat_adder #(
        .DATA_W (DATA_W),
        .INC_W  (INC_W)
    ) u_adder (
        .a   (bram_rdata),
        .b   (inc_q),
        .sum (sum_c),
        .ovf (ovf_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // IDLE arbitration (clear > readout > update) and next-state
    always_comb begin
        state_nxt    = state;
        rd_req_ready = 1'b0;
        upd_ready    = 1'b0;
        rd_hs        = 1'b0;
        upd_hs       = 1'b0;
        case (state)
            IDLE: begin
                rd_req_ready = !rst && !clr_start;
                upd_ready    = !rst && !clr_start && !rd_req_valid;
                rd_hs        = rd_req_valid && rd_req_ready;
                upd_hs       = upd_valid && upd_ready;
                if (clr_start)   state_nxt = CLEAR;
                else if (rd_hs)  state_nxt = RD_ISSUE;
                else if (upd_hs) state_nxt = RMW_RD;
            end
            CLEAR:    if (addr_q == {ADDR_W{1'b1}}) state_nxt = IDLE;
            RMW_RD:   state_nxt = RMW_WAIT;
            RMW_WAIT: state_nxt = RMW_WR;
            RMW_WR:   state_nxt = IDLE;
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Operand capture; addr_q doubles as the clear sweep counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            inc_q  <= '0;
            sum_q  <= '0;
            sat_q  <= 1'b0;
        end else if (state == IDLE) begin
            if (clr_start) begin
                addr_q <= '0;
                sat_q  <= 1'b0;
            end else if (rd_hs) begin
                addr_q <= rd_req_addr;
            end else if (upd_hs) begin
                addr_q <= upd_addr;
                inc_q  <= upd_inc;
            end
        end else if (state == CLEAR) begin
            addr_q <= addr_q + ADDR_W'(1);
        end else if (state == RMW_WAIT) begin
            sum_q <= sum_c;
            if (SAT_EN && ovf_c) sat_q <= 1'b1;
        end
    end

    assign busy          = (state != IDLE);
    assign bram_read_en  = (state == RMW_RD) || (state == RD_ISSUE);
    assign bram_write_en = (state == CLEAR) || (state == RMW_WR);
    assign bram_addr     = addr_q;
    assign bram_wdata    = (state == RMW_WR) ? sum_q : '0;
    assign rd_rsp_valid  = (state == RD_WAIT);
    assign rd_rsp_data   = (state == RD_WAIT) ? bram_rdata : '0;
    assign sat_seen      = sat_q;

endmodule

// File: tb/tb_voxel_bram_initiator.sv
// Self-checking bench for voxel_bram_initiator with a behavioural BRAM and a word-level reference array.
module tb_voxel_bram_initiator;
    import voxel_bram_pkg::*;

    localparam int unsigned AW = VOX_ADDR_W;
    localparam int unsigned DW = VOX_DATA_W;
    localparam int unsigned IW = VOX_INC_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_start = 1'b0;
    logic          busy;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [AW-1:0] upd_addr = '0;
    logic [IW-1:0] upd_inc = '0;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr = '0;
    logic          rd_rsp_valid;
    logic [DW-1:0] rd_rsp_data;
    logic          sat_seen;
    logic          bram_read_en;
    logic          bram_write_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata = '0;

    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    logic [DW-1:0] mem     [VOX_DEPTH];
    logic [DW-1:0] ref_mem [VOX_DEPTH];

    int n_cmp = 0;
    int n_err = 0;
    int overlap_cnt = 0;
    int wr_cnt = 0;
    bit sat_exp = 1'b0;

    always #5 clk = ~clk;

    voxel_bram_initiator dut (
        .clk           (clk),
        .rst           (rst),
        .clr_start     (clr_start),
        .busy          (busy),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_addr      (upd_addr),
        .upd_inc       (upd_inc),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_data   (rd_rsp_data),
        .sat_seen      (sat_seen),
        .bram_read_en  (bram_read_en),
        .bram_write_en (bram_write_en),
        .bram_addr     (bram_addr),
        .bram_wdata    (bram_wdata),
        .bram_rdata    (bram_rdata)
    );

    // Responder BRAM with registered read data; pre_* is a bench-only backdoor write
    always @(posedge clk) begin
        if (bram_write_en)   mem[bram_addr] <= bram_wdata;
        else if (pre_we)     mem[pre_addr]  <= pre_data;
        if (bram_read_en)    bram_rdata     <= mem[bram_addr];
    end

    always @(negedge clk) begin
        if (bram_read_en && bram_write_en) overlap_cnt++;
        if (bram_write_en) wr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference accumulate: 64-bit sum, then clamp or wrap to the counter width
    function automatic logic [DW-1:0] model_add(input logic [DW-1:0] old, input logic [IW-1:0] inc,
                                                output bit sat);
        longint unsigned s;
        longint unsigned max_v;
        max_v = (64'd1 << DW) - 64'd1;
        s = 64'(old) + 64'(inc);
        sat = 1'b0;
`ifdef VOXEL_BRAM_SAT_EN
        if (s > max_v) begin
            sat = 1'b1;
            return DW'(max_v);
        end
`endif
        return DW'(s % (max_v + 64'd1));
    endfunction

    task automatic wait_idle();
        for (int t = 0; t < 64 && busy; t++) @(negedge clk);
        if (busy) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic send_upd(input logic [AW-1:0] a, input logic [IW-1:0] inc);
        bit s;
        @(negedge clk);
        upd_valid = 1'b1; upd_addr = a; upd_inc = inc;
        #1;
        for (int t = 0; t < 64 && !upd_ready; t++) begin @(negedge clk); #1; end
        if (!upd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL upd_hs_timeout: upd_ready=%b required 1", upd_ready);
            upd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        ref_mem[a] = model_add(ref_mem[a], inc, s);
        if (s) sat_exp = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        wait_idle();
    endtask

    task automatic send_rd(input logic [AW-1:0] a, output logic [DW-1:0] data, output int lat,
                           output bit after);
        data = '0; lat = 0; after = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b1; rd_req_addr = a;
        #1;
        for (int t = 0; t < 64 && !rd_req_ready; t++) begin @(negedge clk); #1; end
        if (!rd_req_ready) begin
            n_cmp++; n_err++;
            $display("FAIL rd_hs_timeout: rd_req_ready=%b required 1", rd_req_ready);
            rd_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (t == 1) rd_req_valid = 1'b0;
            if (rd_rsp_valid) begin lat = t; data = rd_rsp_data; break; end
        end
        if (lat == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rd_rsp_timeout: no rd_rsp_valid within 8 cycles");
        end else begin
            @(negedge clk);
            after = rd_rsp_valid;
        end
        wait_idle();
    endtask

    task automatic test_reset();
        logic [85:0] outs;
        #2;
        rd_req_valid = 1'b1; upd_valid = 1'b1; clr_start = 1'b1;
        #1;
        outs = {busy, bram_read_en, bram_write_en, bram_addr, bram_wdata, rd_rsp_valid,
                rd_rsp_data, sat_seen, upd_ready, rd_req_ready};
        n_cmp++;
        if (outs !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h required 0", outs);
        end
        rd_req_valid = 1'b0; upd_valid = 1'b0; clr_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, rd_req_ready, upd_ready} !== 3'b011) begin
            n_err++; $display("FAIL reset_release: busy/rd_rdy/upd_rdy got %b required 011",
                              {busy, rd_req_ready, upd_ready});
        end
    endtask

    task automatic test_clear();
        logic [DW-1:0] d; int lat; bit after; int bad; int wr0;
        logic [AW-1:0] first_bad;
        send_upd(15'h1234, 16'hBEEF);
        send_upd(15'h7FFF, 16'h0042);
        send_upd(AW'($urandom_range(0, VOX_DEPTH - 1)), IW'($urandom));
        @(negedge clk);
        clr_start = 1'b1; upd_valid = 1'b1; upd_addr = 15'h0001; upd_inc = 16'd1;
        #1;
        n_cmp++;
        if ({rd_req_ready, upd_ready} !== 2'b00) begin
            n_err++; $display("FAIL clear_readies: got %b required 00", {rd_req_ready, upd_ready});
        end
        @(posedge clk);
        wr0 = wr_cnt;
        @(negedge clk);
        clr_start = 1'b0; upd_valid = 1'b0;
        bad = 0; first_bad = '0;
        for (int i = 0; i < VOX_DEPTH; i++) begin
            if (!(bram_write_en && !bram_read_en && busy && bram_addr == AW'(i) && bram_wdata == '0)) begin
                if (bad == 0) first_bad = AW'(i);
                bad++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL clear_sweep: %0d bad cycles (first at index %h) required 0", bad, first_bad);
        end
        n_cmp++;
        if (busy !== 1'b0 || bram_write_en !== 1'b0) begin
            n_err++; $display("FAIL clear_end: busy=%b wr_en=%b required 0 0", busy, bram_write_en);
        end
        n_cmp++;
        if (wr_cnt - wr0 != VOX_DEPTH) begin
            n_err++; $display("FAIL clear_count: %0d writes required %0d", wr_cnt - wr0, VOX_DEPTH);
        end
        for (int i = 0; i < VOX_DEPTH; i++) ref_mem[i] = '0;
        sat_exp = 1'b0;
        send_rd(15'h1234, d, lat, after);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL clear_rd_1234: got %h required 00000000", d);
        end
        send_rd(15'h7FFF, d, lat, after);
        n_cmp++;
        if (d !== 32'h0 || lat != 2 || after !== 1'b0) begin
            n_err++; $display("FAIL clear_rd_7fff: data=%h lat=%0d after=%b required 0 2 0", d, lat, after);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d; int lat; bit after; int k; bit wr_ok; bit s;
        @(negedge clk);
        upd_valid = 1'b1; upd_addr = 15'h0005; upd_inc = 16'd3;
        #1;
        n_cmp++;
        if (upd_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_ready: got %b required 1", upd_ready);
        end
        @(posedge clk);
        ref_mem[5] = model_add(ref_mem[5], 16'd3, s);
        k = 0; wr_ok = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk); #1;
            if (t == 3) wr_ok = bram_write_en && !bram_read_en && bram_addr == 15'h0005 && bram_wdata == 32'd3;
            if (upd_ready) begin k = t; break; end
        end
        n_cmp++;
        if (k != 4) begin
            n_err++; $display("FAIL b2b_occupancy: next ready after %0d cycles required 4", k);
        end
        n_cmp++;
        if (!wr_ok) begin
            n_err++; $display("FAIL b2b_write_slot: write not seen at cycle 3 (addr 5 data 3)");
        end
        if (k != 0) begin
            @(posedge clk);
            ref_mem[5] = model_add(ref_mem[5], 16'd3, s);
        end
        @(negedge clk);
        upd_valid = 1'b0;
        wait_idle();
        send_rd(15'h0005, d, lat, after);
        n_cmp++;
        if (d !== 32'd6 || d !== ref_mem[5]) begin
            n_err++; $display("FAIL b2b_result: got %h required 00000006", d);
        end
    endtask

    task automatic test_priority();
        logic [DW-1:0] d; logic [DW-1:0] old_v; int lat; bit after; int k; bit s; bit rsp_seen;
        send_upd(15'h0100, 16'd7);
        old_v = ref_mem[15'h0100];
        @(negedge clk);
        rd_req_valid = 1'b1; rd_req_addr = 15'h0100;
        upd_valid = 1'b1; upd_addr = 15'h0100; upd_inc = 16'd9;
        #1;
        n_cmp++;
        if ({rd_req_ready, upd_ready} !== 2'b10) begin
            n_err++; $display("FAIL prio_readies: rd/upd got %b required 10", {rd_req_ready, upd_ready});
        end
        @(posedge clk);
        k = 0; rsp_seen = 1'b0; d = '0;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t == 1) rd_req_valid = 1'b0;
            #1;
            if (rd_rsp_valid) begin rsp_seen = 1'b1; d = rd_rsp_data; end
            if (upd_ready) begin k = t; break; end
        end
        n_cmp++;
        if (!rsp_seen || d !== old_v || d !== 32'd7) begin
            n_err++; $display("FAIL prio_read_first: seen=%b data=%h required 1 00000007", rsp_seen, d);
        end
        n_cmp++;
        if (k != 3) begin
            n_err++; $display("FAIL prio_upd_after: upd_ready after %0d cycles required 3", k);
        end
        if (k != 0) begin
            @(posedge clk);
            ref_mem[15'h0100] = model_add(ref_mem[15'h0100], 16'd9, s);
        end
        @(negedge clk);
        upd_valid = 1'b0;
        wait_idle();
        send_rd(15'h0100, d, lat, after);
        n_cmp++;
        if (d !== 32'd16) begin
            n_err++; $display("FAIL prio_final: got %h required 00000010", d);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d; int lat; bit after; logic [AW-1:0] a; int bad;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, VOX_DEPTH - 1));
            else                           a = AW'(15'h0010 + $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                send_rd(a, d, lat, after);
                n_cmp++;
                if (d !== ref_mem[a] || lat != 2 || after !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_read[%0d]: addr %h data=%h lat=%0d required %h lat 2", i, a, d, lat, ref_mem[a]);
                end
            end else begin
                send_upd(a, IW'($urandom));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int j = 0; j < 8; j++) begin
            send_rd(AW'(15'h0010 + j), d, lat, after);
            if (d !== ref_mem[15'h0010 + j]) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL rand_sweep: %0d of 8 addresses wrong, required 0", bad);
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] d; int lat; bit after; logic [DW-1:0] exp_d; bit exp_s;
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 15'h0333; pre_data = 32'hFFFF_FFF0;
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[15'h0333] = 32'hFFFF_FFF0;
        n_cmp++;
        if (sat_seen !== 1'b0) begin
            n_err++; $display("FAIL sat_before: sat_seen=%b required 0", sat_seen);
        end
        send_upd(15'h0333, 16'h0020);
`ifdef VOXEL_BRAM_SAT_EN
        exp_d = 32'hFFFF_FFFF; exp_s = 1'b1;
`else
        exp_d = 32'h0000_0010; exp_s = 1'b0;
`endif
        send_rd(15'h0333, d, lat, after);
        n_cmp++;
        if (d !== exp_d || d !== ref_mem[15'h0333]) begin
            n_err++; $display("FAIL sat_result: got %h required %h", d, exp_d);
        end
        n_cmp++;
        if (sat_seen !== exp_s || sat_seen !== sat_exp) begin
            n_err++; $display("FAIL sat_flag: sat_seen=%b required %b", sat_seen, exp_s);
        end
    endtask

    task automatic test_reset_mid();
        logic [85:0] outs;
        @(negedge clk);
        upd_valid = 1'b1; upd_addr = 15'h0022; upd_inc = 16'd1;
        #1;
        for (int t = 0; t < 64 && !upd_ready; t++) begin @(negedge clk); #1; end
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        @(posedge clk);
        #2;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre: busy=%b required 1", busy);
        end
        rst = 1'b1;
        #1;
        outs = {busy, bram_read_en, bram_write_en, bram_addr, bram_wdata, rd_rsp_valid,
                rd_rsp_data, sat_seen, upd_ready, rd_req_ready};
        n_cmp++;
        if (outs !== '0) begin
            n_err++; $display("FAIL rstmid_outputs: got %h required 0", outs);
        end
        rd_req_valid = 1'b1; upd_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({rd_req_ready, upd_ready} !== 2'b00) begin
                n_err++; $display("FAIL rstmid_readies[%0d]: got %b required 00", t, {rd_req_ready, upd_ready});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, rd_req_ready, upd_ready, sat_seen} !== 4'b0100) begin
            n_err++; $display("FAIL rstmid_release: busy/rd/upd/sat got %b required 0100",
                              {busy, rd_req_ready, upd_ready, sat_seen});
        end
        rd_req_valid = 1'b0; upd_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clear();
        test_back_to_back();
        test_priority();
        test_random();
        test_saturation();
        test_reset_mid();
        n_cmp++;
        if (overlap_cnt != 0) begin
            n_err++; $display("FAIL enable_overlap: %0d cycles with both enables, required 0", overlap_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
